// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared fetch definitions: state encodings, reset PC, PC step
//
// Purpose: constants and types shared by the fetch sequencer and its
// surroundings (PCAdder step, default reset PC, FSM state encoding).
// Ports: none (package).

package fetch_sequencer_pkg;

  // Fetch FSM states; encodings are fixed so debug views stay stable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Distance between consecutive instructions; the external PCAdder adds this.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer with PC register, memory handshake and output slot
//
// Purpose: owns the program counter, issues one fetch at a time to
// instruction memory via IMemReq/IMemReady, holds the fetched word in a
// one-entry slot for decode (with Stall backpressure) and handles
// branch/jump redirects that flush an in-flight fetch.
//
// Ports:
//   Clk          in   clock, all state on rising edge
//   Reset        in   synchronous active-high reset
//   Stall        in   decode cannot accept the slot this cycle
//   Redirect     in   one-cycle redirect request
//   RedirectPC   in   [31:0] redirect target (low bits dropped, flagged)
//   PCAddResult  in   [31:0] PCResult + 4 from the external PCAdder
//   PCResult     out  [31:0] current PC, drives the PCAdder
//   IMemReq      out  fetch request
//   IMemAddr     out  [31:0] fetch address
//   IMemReady    in   memory response; transfer = IMemReq & IMemReady
//   IMemData     in   [31:0] instruction word, valid with IMemReady
//   InstrValid   out  output slot holds a word
//   Instruction  out  [31:0] fetched word
//   InstrPC      out  [31:0] address of Instruction
//   Misaligned   out  one-cycle pulse when an accepted redirect was misaligned

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic [31:0] PCAddResult,
  output logic [31:0] PCResult,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        Misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_addr_q, pend_addr_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instruction_q, instruction_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         misaligned_q, misaligned_d;

  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         slot_consumed;
  logic [31:0]  redirect_target;

  assign slot_consumed   = instr_valid_q & ~Stall;
  assign redirect_target = align_pc(RedirectPC);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pend_addr_q   <= 32'h0;
      instr_valid_q <= 1'b0;
      instruction_q <= 32'h0;
      instr_pc_q    <= 32'h0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_addr_q   <= pend_addr_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      instr_pc_q    <= instr_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_addr_d   = pend_addr_q;
    instr_valid_d = instr_valid_q;
    instruction_d = instruction_q;
    instr_pc_d    = instr_pc_q;
    misaligned_d  = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = pc_q;

    case (state_q)
      ST_IDLE: begin
        // Redirects are ignored here; the first fetch goes out next cycle.
        state_d = ST_ISSUE;
      end

      ST_ISSUE: begin
        // A redirect suppresses the request so the stale PC never reaches memory.
        imem_req  = ~Redirect & (~instr_valid_q | ~Stall);
        imem_addr = pc_q;
        if (Redirect) begin
          pc_d          = redirect_target;
          instr_valid_d = 1'b0;
          misaligned_d  = |RedirectPC[1:0];
        end else if (imem_req) begin
          pend_addr_d = pc_q;
          if (IMemReady) begin
            instruction_d = IMemData;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = PCAddResult;
          end else begin
            // Request accepted but not answered; the slot was consumed
            // (or empty), so it is freed while we wait.
            instr_valid_d = 1'b0;
            state_d       = ST_WAIT;
          end
        end else if (slot_consumed) begin
          instr_valid_d = 1'b0;
        end
      end

      ST_WAIT: begin
        // Request and address stay frozen until the memory answers.
        imem_req      = 1'b1;
        imem_addr     = pend_addr_q;
        instr_valid_d = 1'b0;
        if (Redirect) begin
          pc_d         = redirect_target;
          misaligned_d = |RedirectPC[1:0];
          state_d      = IMemReady ? ST_ISSUE : ST_FLUSH;
        end else if (IMemReady) begin
          instruction_d = IMemData;
          instr_pc_d    = pend_addr_q;
          instr_valid_d = 1'b1;
          pc_d          = PCAddResult;
          state_d       = ST_ISSUE;
        end
      end

      ST_FLUSH: begin
        // Drain the abandoned request; its data is dropped and PC kept.
        imem_req      = 1'b1;
        imem_addr     = pend_addr_q;
        instr_valid_d = 1'b0;
        if (Redirect) begin
          // A later redirect replaces the earlier target.
          pc_d         = redirect_target;
          misaligned_d = |RedirectPC[1:0];
        end
        if (IMemReady) begin
          state_d = ST_ISSUE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign PCResult    = pc_q;
  assign IMemReq     = imem_req;
  assign IMemAddr    = imem_addr;
  assign InstrValid  = instr_valid_q;
  assign Instruction = instruction_q;
  assign InstrPC     = instr_pc_q;
  assign Misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer

module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] PCAddResult;
  logic [31:0] PCResult;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        Misaligned;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [3:0] mem_lat;
  logic [3:0] wait_cnt;

  always #5 Clk = ~Clk;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .PCAddResult(PCAddResult), .PCResult(PCResult),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemData(IMemData), .InstrValid(InstrValid), .Instruction(Instruction),
    .InstrPC(InstrPC), .Misaligned(Misaligned)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // External PCAdder and a memory answering after mem_lat waiting cycles.
  assign PCAddResult = PCResult + PC_STEP;
  assign IMemReady   = IMemReq && (wait_cnt >= mem_lat);
  assign IMemData    = mdata(IMemAddr);

  always @(posedge Clk) begin
    if (Reset || !IMemReq || IMemReady) wait_cnt <= 4'd0;
    else                                wait_cnt <= wait_cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; mem_lat = 4'd0;
    tick; tick;
    settle;
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_req", {31'h0, IMemReq}, 32'h0);
    chk("rst_valid", {31'h0, InstrValid}, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_ipc", InstrPC, 32'h0);
    chk("rst_mis", {31'h0, Misaligned}, 32'h0);

    // Reset deasserted: IDLE this cycle, first request next cycle.
    Reset = 1'b0;
    settle;
    chk("idle_req", {31'h0, IMemReq}, 32'h0);
    tick;

    // Zero-latency streaming: one fetch per cycle (c1..c4).
    for (int k = 0; k < 4; k++) begin
      settle;
      chk("z_req", {31'h0, IMemReq}, 32'h1);
      chk("z_addr", IMemAddr, 32'(4 * k));
      chk("z_valid", {31'h0, InstrValid}, (k == 0) ? 32'h0 : 32'h1);
      if (k > 0) begin
        chk("z_ipc", InstrPC, 32'(4 * (k - 1)));
        chk("z_instr", Instruction, mdata(32'(4 * (k - 1))));
      end
      tick;
    end

    // Latency 3: request for 16 held four cycles (c5..c8).
    mem_lat = 4'd3;
    for (int j = 0; j < 4; j++) begin
      settle;
      chk("l_req", {31'h0, IMemReq}, 32'h1);
      chk("l_addr", IMemAddr, 32'd16);
      chk("l_valid", {31'h0, InstrValid}, (j == 0) ? 32'h1 : 32'h0);
      if (j == 0) chk("l_ipc12", InstrPC, 32'd12);
      tick;
    end

    // c9: word 16 in slot; stall for five cycles.
    Stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      settle;
      chk("s_req", {31'h0, IMemReq}, 32'h0);
      chk("s_valid", {31'h0, InstrValid}, 32'h1);
      chk("s_ipc", InstrPC, 32'd16);
      chk("s_instr", Instruction, mdata(32'd16));
      tick;
    end

    // c14: stall released, request goes out the same cycle.
    Stall = 1'b0;
    settle;
    chk("us_req", {31'h0, IMemReq}, 32'h1);
    chk("us_addr", IMemAddr, 32'd20);
    tick;

    // c15: WAIT, redirect to 0x100.
    Redirect = 1'b1; RedirectPC = 32'h0000_0100;
    settle;
    chk("w_req", {31'h0, IMemReq}, 32'h1);
    chk("w_addr", IMemAddr, 32'd20);
    chk("w_valid", {31'h0, InstrValid}, 32'h0);
    tick;

    // c16: FLUSH, old request still held.
    Redirect = 1'b0;
    settle;
    chk("f_pc", PCResult, 32'h100);
    chk("f_req", {31'h0, IMemReq}, 32'h1);
    chk("f_addr", IMemAddr, 32'd20);
    chk("f_valid", {31'h0, InstrValid}, 32'h0);
    tick;

    // c17: old response arrives and is discarded.
    settle;
    chk("f_ready", {31'h0, IMemReady}, 32'h1);
    chk("f_addr2", IMemAddr, 32'd20);
    tick;

    // c18..c21: fetch of 0x100, slot stays empty.
    for (int j = 0; j < 4; j++) begin
      settle;
      chk("r_req", {31'h0, IMemReq}, 32'h1);
      chk("r_addr", IMemAddr, 32'h100);
      chk("r_valid", {31'h0, InstrValid}, 32'h0);
      tick;
    end

    // c22: word 0x100 delivered; misaligned redirect to 0x102.
    mem_lat = 4'd0;
    Redirect = 1'b1; RedirectPC = 32'h0000_0102;
    settle;
    chk("r_ipc", InstrPC, 32'h100);
    chk("r_instr", Instruction, mdata(32'h100));
    chk("r_valid1", {31'h0, InstrValid}, 32'h1);
    chk("rd_req", {31'h0, IMemReq}, 32'h0);
    chk("rd_mis0", {31'h0, Misaligned}, 32'h0);
    tick;

    // c23: aligned PC, Misaligned pulse.
    Redirect = 1'b0;
    settle;
    chk("m_pc", PCResult, 32'h100);
    chk("m_mis", {31'h0, Misaligned}, 32'h1);
    chk("m_valid", {31'h0, InstrValid}, 32'h0);
    chk("m_addr", IMemAddr, 32'h100);
    tick;

    // c24: pulse over; redirect to the top word.
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    settle;
    chk("m_mis_end", {31'h0, Misaligned}, 32'h0);
    chk("m_ipc", InstrPC, 32'h100);
    tick;

    // c25..c27: wrap from 0xFFFFFFFC to 0.
    Redirect = 1'b0;
    settle;
    chk("wr_pc", PCResult, 32'hFFFF_FFFC);
    chk("wr_addr", IMemAddr, 32'hFFFF_FFFC);
    chk("wr_mis", {31'h0, Misaligned}, 32'h0);
    tick;
    settle;
    chk("wr_addr0", IMemAddr, 32'h0);
    chk("wr_ipc", InstrPC, 32'hFFFF_FFFC);
    chk("wr_instr", Instruction, mdata(32'hFFFF_FFFC));
    tick;
    mem_lat = 4'd3;
    settle;
    chk("wr_ipc0", InstrPC, 32'h0);
    chk("wr_addr4", IMemAddr, 32'h4);
    tick;

    // c28: WAIT on address 4; reset mid-fetch.
    settle;
    chk("rw_req", {31'h0, IMemReq}, 32'h1);
    chk("rw_valid", {31'h0, InstrValid}, 32'h0);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    settle;
    chk("rr_pc", PCResult, 32'h0);
    chk("rr_req", {31'h0, IMemReq}, 32'h0);
    chk("rr_valid", {31'h0, InstrValid}, 32'h0);
    chk("rr_instr", Instruction, 32'h0);
    chk("rr_ipc", InstrPC, 32'h0);
    chk("rr_mis", {31'h0, Misaligned}, 32'h0);
    tick;
    settle;
    chk("rr_req1", {31'h0, IMemReq}, 32'h1);
    chk("rr_addr", IMemAddr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
